// File: rtl/i4001_bus.sv
// rtl/i4001_bus.sv - Intel 4001 ROM/I-O chip emulation on the 4004 multiplexed bus
module i4001_bus #(
    parameter logic [3:0] CHIP_ID = 4'h0
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       SYNC,
    input  logic       CM,
    input  logic [3:0] D_IN,
    output logic [3:0] D_OUT,
    output logic       D_OE,
    output logic [7:0] rom_addr,
    input  logic [7:0] rom_data,
    input  logic [3:0] IO_IN,
    output logic [3:0] IO_OUT,
    output logic [3:0] PHASE
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_A1   = 4'd1,
        S_A2   = 4'd2,
        S_A3   = 4'd3,
        S_M1   = 4'd4,
        S_M2   = 4'd5,
        S_X1   = 4'd6,
        S_X2   = 4'd7,
        S_X3   = 4'd8
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_addr_lo;
    logic [7:0] r_opr_opa;
    logic       r_rom_sel;
    logic       r_selected;
    logic       r_io_pending;
    logic [3:0] r_io_opa;
    logic       w_chip_hit;
    logic       w_src;
    logic       w_wrr;
    logic       w_rdr_next;

    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE:  w_next = S_IDLE;
            S_A1:    w_next = S_A2;
            S_A2:    w_next = S_A3;
            S_A3:    w_next = S_M1;
            S_M1:    w_next = S_M2;
            S_M2:    w_next = S_X1;
            S_X1:    w_next = S_X2;
            S_X2:    w_next = S_X3;
            S_X3:    w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (SYNC) begin
            w_next = S_A1;
        end
    end

    assign w_chip_hit = (D_IN == CHIP_ID);
    assign w_src      = (r_state == S_X2) && CM;
    // An early SYNC landing on X2 aborts the cycle, so it must also block the write.
    assign w_wrr      = (r_state == S_X2) && !SYNC && r_io_pending && r_selected
                        && (r_io_opa == 4'h2);
    assign w_rdr_next = (w_next == S_X2) && r_io_pending && r_selected
                        && (r_io_opa == 4'hA);
    assign PHASE      = r_state;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state      <= S_IDLE;
            r_addr_lo    <= 4'h0;
            r_opr_opa    <= 8'h00;
            r_rom_sel    <= 1'b0;
            r_selected   <= 1'b0;
            r_io_pending <= 1'b0;
            r_io_opa     <= 4'h0;
            rom_addr     <= 8'h00;
            IO_OUT       <= 4'h0;
            D_OUT        <= 4'h0;
            D_OE         <= 1'b0;
        end else begin
            r_state <= w_next;

            if (r_state == S_A1) begin
                r_addr_lo <= D_IN;
            end
            if (r_state == S_A2) begin
                rom_addr <= {D_IN, r_addr_lo};
            end
            if (r_state == S_A3) begin
                r_rom_sel <= w_chip_hit;
                r_opr_opa <= rom_data;
            end

            if (r_state == S_M2) begin
                r_io_opa <= D_IN;
            end
            if (SYNC || (r_state == S_X3)) begin
                r_io_pending <= 1'b0;
            end else if (r_state == S_M2) begin
                r_io_pending <= CM;
            end

            if (w_src) begin
                r_selected <= w_chip_hit;
            end
            if (w_wrr) begin
                IO_OUT <= D_IN;
            end

            // M1 is entered on the same edge that captures the byte, so use the live inputs.
            D_OE  <= 1'b0;
            D_OUT <= 4'h0;
            case (w_next)
                S_M1: begin
                    D_OE  <= w_chip_hit;
                    D_OUT <= rom_data[7:4];
                end
                S_M2: begin
                    D_OE  <= r_rom_sel;
                    D_OUT <= r_opr_opa[3:0];
                end
                S_X2: begin
                    if (w_rdr_next) begin
                        D_OE  <= 1'b1;
                        D_OUT <= IO_IN;
                    end
                end
                default: begin
                    D_OE  <= 1'b0;
                    D_OUT <= 4'h0;
                end
            endcase
        end
    end

endmodule
